// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the mode encodings and the mode field width used by the top
// module, the bit cell and any client logic that drives the mode select.
package usr_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

endpackage

// File: rtl/usr_bit_cell.sv
// Next-state selector for one bit of the universal shift register.
// Ports:
//   self_bit   current value of this bit
//   left_bit   value arriving from the more significant side
//              (used by SHR / ROR / ASR)
//   right_bit  value arriving from the less significant side
//              (used by SHL / ROL)
//   d_bit      parallel load data for this bit
//   reset_bit  this bit of the reset / clear value
//   mode       operation select
//   en         clock enable
//   n_clr      synchronous active-low clear
//   nxt_c      combinational next value for this bit
module usr_bit_cell
   import usr_pkg::*;
(
   input  logic              self_bit,
   input  logic              left_bit,
   input  logic              right_bit,
   input  logic              d_bit,
   input  logic              reset_bit,
   input  logic [MODE_W-1:0] mode,
   input  logic              en,
   input  logic              n_clr,
   output logic              nxt_c
);

   // Clear beats enable, enable beats mode; unknown modes hold.
   always_comb begin
      nxt_c = self_bit;
      if (!n_clr) begin
         nxt_c = reset_bit;
      end else if (en) begin
         case (mode)
            MODE_LOAD:                      nxt_c = d_bit;
            MODE_SHL, MODE_ROL:             nxt_c = right_bit;
            MODE_SHR, MODE_ROR, MODE_ASR:   nxt_c = left_bit;
            default:                        nxt_c = self_bit;
         endcase
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, parallel load, logical
// shift left/right, rotate left/right and arithmetic shift right, with
// serial in/out at both ends and a registered zero flag.
// Ports:
//   clk      rising-edge clock
//   n_reset  asynchronous active-low reset (loads RESET_VALUE)
//   n_clr    synchronous active-low clear (loads RESET_VALUE)
//   en       clock enable, 0 holds
//   mode     operation select (usr_pkg encodings)
//   d        parallel load data
//   sin_l    serial in at the MSB for SHR
//   sin_r    serial in at the LSB for SHL
//   q        register contents
//   q_bar    bitwise inverse of q
//   sout_l   MSB of q
//   sout_r   LSB of q
//   zero     registered flag, 1 when q is all zeros
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              n_clr,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_l,
   input  logic              sin_r,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  q_bar,
   output logic              sout_l,
   output logic              sout_r,
   output logic              zero
);

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_nxt;
   logic             z;
   logic             left_end;
   logic             right_end;
   logic [WIDTH:0]   left_src;
   logic [WIDTH:0]   right_src;

   // Values entering the two ends of the register depend on the mode.
   always_comb begin
      right_end = sin_r;
      left_end  = sin_l;
      if (mode == MODE_ROL) begin
         right_end = r[WIDTH-1];
      end
      if (mode == MODE_ROR) begin
         left_end = r[0];
      end else if (mode == MODE_ASR) begin
         left_end = r[WIDTH-1];
      end
   end

   // Extended neighbour vectors so every cell indexes uniformly.
   assign left_src  = {left_end, r};
   assign right_src = {r, right_end};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      usr_bit_cell u_cell (
         .self_bit  (r[i]),
         .left_bit  (left_src[i+1]),
         .right_bit (right_src[i]),
         .d_bit     (d[i]),
         .reset_bit (RESET_VALUE[i]),
         .mode      (mode),
         .en        (en),
         .n_clr     (n_clr),
         .nxt_c     (r_nxt[i])
      );
   end

   // State register and zero flag; the flag tracks the value being loaded
   // so it is valid in the same cycle q changes.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r <= RESET_VALUE;
         z <= (RESET_VALUE == '0);
      end else begin
         r <= r_nxt;
         z <= (r_nxt == '0);
      end
   end

   assign q      = r;
   assign q_bar  = ~r;
   assign sout_l = r[WIDTH-1];
   assign sout_r = r[0];
   assign zero   = z;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: an 8-bit instance with a
// zero reset value and a 2-bit instance with reset value 2'b01 share the
// same stimulus and are both checked against an arithmetic model.
module tb_universal_shift_reg;

   localparam logic [2:0] M_HOLD = 3'd0;
   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_ROR  = 3'd5;
   localparam logic [2:0] M_ASR  = 3'd6;
   localparam logic [2:0] M_RSVD = 3'd7;

   localparam logic [7:0] RV8 = 8'h00;
   localparam logic [7:0] RV2 = 8'h01;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       n_clr;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_l;
   logic       sin_r;

   logic [7:0] q8;
   logic [7:0] qb8;
   logic       sl8;
   logic       sr8;
   logic       z8;
   logic [1:0] q2;
   logic [1:0] qb2;
   logic       sl2;
   logic       sr2;
   logic       z2;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   run   = 1'b0;
   logic [7:0] m8;
   logic [7:0] m2;

   universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut8 (
      .clk(clk), .n_reset(n_reset), .n_clr(n_clr), .en(en), .mode(mode),
      .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q8), .q_bar(qb8),
      .sout_l(sl8), .sout_r(sr8), .zero(z8)
   );

   universal_shift_reg #(.WIDTH(2), .RESET_VALUE(2'b01)) u_dut2 (
      .clk(clk), .n_reset(n_reset), .n_clr(n_clr), .en(en), .mode(mode),
      .d(d[1:0]), .sin_l(sin_l), .sin_r(sin_r), .q(q2), .q_bar(qb2),
      .sout_l(sl2), .sout_r(sr2), .zero(z2)
   );

   always #5 clk = ~clk;

   // Arithmetic model of one clock edge for a register of width w.
   function automatic logic [7:0] model_next(input logic [7:0] cur, input int w,
                                             input logic [7:0] rv);
      logic [7:0] mask;
      logic [7:0] msb;
      mask = 8'((1 << w) - 1);
      msb  = 8'(1 << (w - 1));
      if (!n_clr) return rv;
      if (!en) return cur;
      case (mode)
         M_LOAD:  return d & mask;
         M_SHL:   return ((cur << 1) | 8'(sin_r)) & mask;
         M_SHR:   return (cur >> 1) | (sin_l ? msb : 8'h00);
         M_ROL:   return ((cur << 1) | (cur >> (w - 1))) & mask;
         M_ROR:   return (cur >> 1) | (cur[0] ? msb : 8'h00);
         M_ASR:   return (cur >> 1) | (cur & msb);
         default: return cur;
      endcase
   endfunction

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         m8 <= RV8;
         m2 <= RV2;
      end else begin
         m8 <= model_next(m8, 8, RV8);
         m2 <= model_next(m2, 2, RV2);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(posedge clk) begin
      #1;
      if (run) begin
         chk("q8",      q8,             m8);
         chk("q_bar8",  qb8,            ~m8);
         chk("sout_l8", {7'b0, sl8},    {7'b0, m8[7]});
         chk("sout_r8", {7'b0, sr8},    {7'b0, m8[0]});
         chk("zero8",   {7'b0, z8},     {7'b0, (m8 == 8'h00)});
         chk("q2",      {6'b0, q2},     m2 & 8'h03);
         chk("q_bar2",  {6'b0, qb2},    ~m2 & 8'h03);
         chk("sout_l2", {7'b0, sl2},    {7'b0, m2[1]});
         chk("sout_r2", {7'b0, sr2},    {7'b0, m2[0]});
         chk("zero2",   {7'b0, z2},     {7'b0, ((m2 & 8'h03) == 8'h00)});
      end
   end

   // Drive one cycle of inputs, then return 2 time units after the edge.
   task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] dv,
                        input logic sl, input logic sr, input logic c);
      en    = e;
      mode  = m;
      d     = dv;
      sin_l = sl;
      sin_r = sr;
      n_clr = c;
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_reset = 1'b0;
      n_clr   = 1'b1;
      en      = 1'b0;
      mode    = M_HOLD;
      d       = 8'h00;
      sin_l   = 1'b0;
      sin_r   = 1'b0;
      #12;
      n_reset = 1'b1;
      run     = 1'b1;
      @(posedge clk);
      #2;

      // Asynchronous reset in the middle of a cycle.
      apply(1, M_LOAD, 8'hA5, 0, 0, 1);
      chk("load_a5", q8, 8'hA5);
      #1;
      n_reset = 1'b0;
      #1;
      chk("async_q",     q8,              8'h00);
      chk("async_q_bar", qb8,             8'hFF);
      chk("async_zero",  {7'b0, z8},      8'h01);
      chk("async_q2",    {6'b0, q2},      8'h01);
      chk("async_zero2", {7'b0, z2},      8'h00);
      @(posedge clk);
      #3;
      n_reset = 1'b1;

      // Rotates and arithmetic shift.
      apply(1, M_LOAD, 8'h81, 0, 0, 1);
      apply(1, M_ROL,  8'h00, 1, 1, 1);
      chk("rol", q8, 8'h03);
      apply(1, M_ROR,  8'h00, 1, 1, 1);
      apply(1, M_ROR,  8'h00, 1, 1, 1);
      chk("ror2", q8, 8'hC0);
      chk("ror2_w2", {6'b0, q2}, 8'h02);
      apply(1, M_ASR,  8'h00, 0, 0, 1);
      chk("asr", q8, 8'hE0);
      chk("asr_w2", {6'b0, q2}, 8'h03);

      // Fill with ones from the LSB.
      apply(1, M_LOAD, 8'h00, 0, 0, 1);
      chk("load_zero_flag", {7'b0, z8}, 8'h01);
      for (int k = 0; k < 8; k++) begin
         apply(1, M_SHL, 8'h00, 0, 1, 1);
         chk("shl_q",      q8,          8'((1 << (k + 1)) - 1));
         chk("shl_zero",   {7'b0, z8},  8'h00);
         chk("shl_sout_l", {7'b0, sl8}, (k == 7) ? 8'h01 : 8'h00);
      end

      // Logical shift right with zero fill.
      apply(1, M_LOAD, 8'hF0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         apply(1, M_SHR, 8'h00, 0, 1, 1);
         chk("shr_sout_r", {7'b0, sr8}, (k == 3) ? 8'h01 : 8'h00);
         chk("shr_zero",   {7'b0, z8},  8'h00);
      end
      chk("shr_q", q8, 8'h0F);

      // Enable low and reserved mode both hold.
      apply(1, M_LOAD, 8'h3C, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         apply(0, M_SHL, 8'hFF, 1, 1, 1);
         chk("en_low_hold", q8, 8'h3C);
      end
      apply(1, M_RSVD, 8'hFF, 1, 1, 1);
      chk("rsvd_hold", q8, 8'h3C);
      apply(1, M_HOLD, 8'hFF, 1, 1, 1);
      chk("mode_hold", q8, 8'h3C);

      // Clear wins over load.
      apply(1, M_LOAD, 8'h55, 0, 0, 0);
      chk("clr_q",     q8,          8'h00);
      chk("clr_zero",  {7'b0, z8},  8'h01);
      chk("clr_q2",    {6'b0, q2},  8'h01);
      chk("clr_zero2", {7'b0, z2},  8'h00);
      apply(1, M_HOLD, 8'h00, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
